imm_pack: RTL and testbench

- Inverse of the decode-side immediate extender. Takes a 32-bit signed immediate, an immsrc selector and a base instruction word, and scatters the immediate into the I/S/B/J bit fields.
- Flags immediates that cannot be represented exactly.
- Two-stage valid/ready pipeline. Used by the boot-time program loader and by testbench stimulus generation to build instruction words.

---
 rtl/imm_pack.sv | 165 ++++++++++++++++
 tb/tb_imm_pack.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_pack.sv
// Packs a signed immediate into the I/S/B/J fields of a base instruction word.
// Two-stage valid/ready pipeline; `define IMM_PACK_ERRCNT_EN to build the error counter.
module imm_pack #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       immsrc,
    input  logic [31:0]      imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned XLEN  = 32;
    // Highest immediate bit ever scattered is imm[20] (J-type).
    localparam int unsigned IMM_W = 21;

    typedef enum logic [1:0] {
        SRC_I = 2'b00,
        SRC_S = 2'b01,
        SRC_B = 2'b10,
        SRC_J = 2'b11
    } immsrc_e;

    logic             s1_valid_q, s1_valid_d;
    immsrc_e          s1_src_q, s1_src_d;
    logic [IMM_W-1:0] s1_imm_q, s1_imm_d;
    logic [XLEN-1:0]  s1_base_q, s1_base_d;
    logic             s1_err_q, s1_err_d;
    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic             out_err_q, out_err_d;

    logic             advance_s1;
    logic             in_fire;
    logic             in_err_c;
    logic [XLEN-1:0]  packed_c;

    assign advance_s1 = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || advance_s1;
    assign in_fire    = in_valid && in_ready;

    // Representability check on the incoming immediate.
    always_comb begin
        in_err_c = 1'b0;
        unique case (immsrc_e'(immsrc))
            SRC_I, SRC_S: in_err_c = !((&imm[31:11]) || !(|imm[31:11]));
            SRC_B:        in_err_c = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            SRC_J:        in_err_c = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
        endcase
    end

    // Field scatter from the S1 registers; untouched bits come from base.
    always_comb begin
        packed_c = s1_base_q;
        unique case (s1_src_q)
            SRC_I: packed_c[31:20] = s1_imm_q[11:0];
            SRC_S: begin
                packed_c[31:25] = s1_imm_q[11:5];
                packed_c[11:7]  = s1_imm_q[4:0];
            end
            SRC_B: begin
                packed_c[31]    = s1_imm_q[12];
                packed_c[30:25] = s1_imm_q[10:5];
                packed_c[11:8]  = s1_imm_q[4:1];
                packed_c[7]     = s1_imm_q[11];
            end
            SRC_J: begin
                packed_c[31]    = s1_imm_q[20];
                packed_c[30:21] = s1_imm_q[10:1];
                packed_c[20]    = s1_imm_q[11];
                packed_c[19:12] = s1_imm_q[19:12];
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_src_d   = s1_src_q;
        s1_imm_d   = s1_imm_q;
        s1_base_d  = s1_base_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        instr_d    = instr_q;
        out_err_d  = out_err_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_src_d   = immsrc_e'(immsrc);
            s1_imm_d   = imm[IMM_W-1:0];
            s1_base_d  = base;
            s1_err_d   = in_err_c;
        end else if (advance_s1) begin
            s1_valid_d = 1'b0;
        end

        if (advance_s1) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d   = packed_c;
                out_err_d = s1_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= SRC_I;
            s1_imm_q   <= '0;
            s1_base_q  <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            out_err_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_src_q   <= s1_src_d;
            s1_imm_q   <= s1_imm_d;
            s1_base_q  <= s1_base_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            instr_q    <= instr_d;
            out_err_q  <= out_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign instr     = instr_q;
    assign out_err   = out_err_q;

`ifdef IMM_PACK_ERRCNT_EN
    logic             out_fire;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign out_fire = s2_valid_q && out_ready;

    // Saturating count of errored results handed to the consumer.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_fire && out_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: range/field model with scoreboard plus directed vectors.
module tb_imm_pack;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       immsrc;
    logic [31:0]      imm;
    logic [31:0]      base;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             out_err;
    logic [CNT_W-1:0] err_count;

    imm_pack #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .imm(imm), .base(base),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [1:0]  src;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } log_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   model_cnt = 0;
`ifdef IMM_PACK_ERRCNT_EN
    int   cnt_max = (1 << CNT_W) - 1;
`else
    int   cnt_max = 0;
`endif
    exp_t sb[$];
    log_t olog[$];
    bit   hold = 1'b0;
    logic [31:0] hold_instr;
    logic        hold_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Destination immediate bit for each instruction bit, or -1 when it comes from base.
    function automatic int field_map(input logic [1:0] src, input int p);
        case (src)
            2'd0: if (p >= 20) return p - 20;
            2'd1: begin
                if (p >= 25) return p - 20;
                if (p >= 7 && p <= 11) return p - 7;
            end
            2'd2: begin
                if (p == 31) return 12;
                if (p >= 25) return p - 20;
                if (p >= 8 && p <= 11) return p - 7;
                if (p == 7) return 11;
            end
            default: begin
                if (p == 31) return 20;
                if (p >= 21) return p - 20;
                if (p == 20) return 11;
                if (p >= 12) return p;
            end
        endcase
        return -1;
    endfunction

    function automatic exp_t model(input logic [1:0] src, input logic [31:0] v, input logic [31:0] b);
        exp_t e;
        int   idx;
        int   sv;
        sv = int'($signed(v));
        e.instr = b;
        for (int p = 0; p < 32; p++) begin
            idx = field_map(src, p);
            if (idx >= 0) e.instr[p] = v[idx];
        end
        case (src)
            2'd0, 2'd1: e.err = (sv < -2048) || (sv > 2047);
            2'd2:       e.err = (sv < -4096) || (sv > 4095) || v[0];
            default:    e.err = (sv < -(1 << 20)) || (sv >= (1 << 20)) || v[0];
        endcase
        e.imm = v;
        e.src = src;
        return e;
    endfunction

    // Decode-side extender, used for the round-trip property.
    function automatic logic [31:0] extend(input logic [31:0] i, input logic [1:0] src);
        case (src)
            2'd0:    return {{20{i[31]}}, i[31:20]};
            2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    // Per-cycle compare: counter, hold-stable, scoreboard order and contents.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            sb.delete();
            model_cnt = 0;
            hold = 1'b0;
        end else begin
            check("err_count", 32'(err_count), 32'(model_cnt));
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_instr", instr, hold_instr);
                check("hold_err", 32'(out_err), 32'(hold_err));
            end
            hold       = out_valid && !out_ready;
            hold_instr = instr;
            hold_err   = out_err;
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got instr %h with nothing pending (cycle %0d)", instr, cyc);
                end else begin
                    e = sb.pop_front();
                    if (instr !== e.instr || out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL sb_result: got %h/%b expected %h/%b (cycle %0d)",
                                 instr, out_err, e.instr, e.err, cyc);
                    end
                    if (!e.err) check("roundtrip", extend(instr, e.src), e.imm);
                end
                olog.push_back('{instr: instr, err: out_err, cyc: cyc});
                if (out_err && model_cnt < cnt_max) model_cnt++;
            end
            if (in_valid && in_ready) sb.push_back(model(immsrc, imm, base));
        end
    end

    task automatic send(input logic [1:0] s, input logic [31:0] v, input logic [31:0] b);
        bit acc = 1'b0;
        in_valid = 1'b1;
        immsrc   = s;
        imm      = v;
        base     = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no in_ready expected accept of imm %h", v);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    endtask

    task automatic check_last(input string name, input logic [31:0] ei, input logic ee);
        log_t l;
        if (olog.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no output expected %h", name, ei);
            return;
        end
        l = olog[olog.size() - 1];
        check({name, "_instr"}, l.instr, ei);
        check({name, "_err"}, 32'(l.err), 32'(ee));
    endtask

    initial begin
        int exp_cnt[5];
        int n0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        immsrc = 2'd0; imm = '0; base = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_instr", instr, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;

        // I-type, with latency pinned
        send(2'b00, 32'hFFFFF800, 32'h00000013);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        drain();
        check_last("i_type", 32'h80000013, 1'b0);

        send(2'b10, 32'hFFFFFFFC, 32'h00000063);
        drain();
        check_last("b_neg4", 32'hFE000EE3, 1'b0);
        send(2'b10, 32'h00000005, 32'h00000063);
        drain();
        check_last("b_odd", 32'h00000263, 1'b1);

        send(2'b11, 32'h00000800, 32'h0000006F);
        drain();
        check_last("j_800", 32'h0010006F, 1'b0);
        check("j_roundtrip", extend(olog[olog.size() - 1].instr, 2'b11), 32'h00000800);

        send(2'b01, 32'hFFFFFFFF, 32'h00000023);
        drain();
        check_last("s_m1", 32'hFE000FA3, 1'b0);

        // Out-of-range counter run
`ifdef IMM_PACK_ERRCNT_EN
        exp_cnt = '{1, 2, 3, 3, 3};
`else
        exp_cnt = '{0, 0, 0, 0, 0};
`endif
        for (int k = 0; k < 5; k++) begin
            send(2'b00, 32'h00000800, 32'h00000013);
            drain();
            check_last("cnt_req", 32'h80000013, 1'b1);
            check("cnt_value", 32'(err_count), 32'(exp_cnt[k]));
        end

        // Backpressure: two accepted, then stall, then gapless drain
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(2'b00, 32'd1, 32'h00000013);
        send(2'b00, 32'd2, 32'h00000013);
        in_valid = 1'b1; immsrc = 2'b00; imm = 32'd3; base = 32'h00000013;
        @(negedge clk);
        check("bp_in_ready_a", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_in_ready_b", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", instr, 32'h00100013);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n0 = olog.size();
        send(2'b00, 32'd3, 32'h00000013);
        send(2'b00, 32'd4, 32'h00000013);
        drain();
        check("bp_count", 32'(olog.size() - n0), 32'd4);
        if (olog.size() - n0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("bp_order", olog[n0 + k].instr, 32'h00000013 | (32'(k + 1) << 20));
                if (k > 0) check("bp_no_gap", 32'(olog[n0 + k].cyc - olog[n0 + k - 1].cyc), 32'd1);
            end
        end

        // Reset with both stages full
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(2'b00, 32'd5, 32'h00000013);
        send(2'b00, 32'd6, 32'h00000013);
        @(negedge clk);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        n0 = olog.size();
        repeat (5) @(negedge clk);
        check("mid_rst_no_stale", 32'(olog.size() - n0), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule
